// File: rtl/stack_pkg.sv
// Shared types and constants for the stack command front end.
// Holds the command FSM state encoding, the default stack depth and the
// data byte width used by the top level and the testbench.
package stack_pkg;

  // Default number of stack entries tracked by the occupancy counter.
  localparam int unsigned STACK_DEPTH = 256;

  // Width of the byte carried with a push command.
  localparam int unsigned DATA_W = 8;

  // Command FSM. Only ST_IDLE accepts requests; each command owns the
  // stack stage for two cycles before returning to idle.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PUSH1 = 3'd1,
    ST_PUSH2 = 3'd2,
    ST_POP1  = 3'd3,
    ST_POP2  = 3'd4
  } state_t;

  // True for the two states that drive the push command.
  function automatic logic is_push_state(input state_t st);
    return (st == ST_PUSH1) || (st == ST_PUSH2);
  endfunction

  // True for the two states that drive the pop command.
  function automatic logic is_pop_state(input state_t st);
    return (st == ST_POP1) || (st == ST_POP2);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: synchronize and debounce one raw switch, emit a one-cycle pulse on press.
// Latency: 2 sync cycles + DB_CYCLES stable samples before the pulse appears.
// Backpressure: none; the pulse is dropped if the consumer is not ready for it.
//
// Ports:
//   clk     - clock, all state on rising edge
//   rst_n   - asynchronous active-low reset (already release-synchronized)
//   i_btn   - raw asynchronous switch level, active high
//   o_rise  - one-cycle pulse on the rising edge of the debounced level
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_d;
  logic [DB_W-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous switch input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // The counter runs only while the synchronized sample disagrees with the
  // accepted level. With a binary input, "differs from the accepted level for
  // N samples in a row" is the same as "N consecutive equal samples", and any
  // sample matching the old level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  // Single pulse per press; a held button produces no repeats.
  assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/stack_cmd_frontend.sv
// Purpose: turn debounced push/pop buttons into 2-cycle stack commands with occupancy tracking.
// Latency: request pulse at N -> push_o/pop_o high at N+1,N+2; count_o updated at N+3.
// Backpressure: none; requests while busy, full/empty, or simultaneous are dropped.
//
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   btn_push, btn_pop   - raw asynchronous switches, active high
//   data_in             - byte captured when a push is accepted
//   push_o, pop_o       - command strobes to the stack stage (2 cycles each)
//   data_o              - captured push byte, held through and after the push window
//   count_o             - occupancy 0..DEPTH; full_o / empty_o decode it
//   err_o               - sticky rejected-command flag
//
// Build option: define STACK_CMD_ERR_EN to enable err_o; otherwise it is tied low.
module stack_cmd_frontend
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH     = STACK_DEPTH,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_push,
  input  logic                     btn_pop,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     push_o,
  output logic                     pop_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              r_rst_meta;
  logic              r_rst_sync;
  logic              w_rst_n;
  logic              w_push_req;
  logic              w_pop_req;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_count;

  // Reset asserts immediately everywhere but releases on a clock edge, so no
  // flop sees reset removal near its active edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_push (
    .clk    (clk),
    .rst_n  (w_rst_n),
    .i_btn  (btn_push),
    .o_rise (w_push_req)
  );

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_pop (
    .clk    (clk),
    .rst_n  (w_rst_n),
    .i_btn  (btn_pop),
    .o_rise (w_pop_req)
  );

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A request is accepted only in idle, only when alone, and only when the
  // stack has room (push) or content (pop). This is what keeps the count
  // from ever wrapping.
  assign w_push_ok = (r_state == ST_IDLE) && w_push_req && !w_pop_req && !w_full;
  assign w_pop_ok  = (r_state == ST_IDLE) && w_pop_req && !w_push_req && !w_empty;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_push_ok) begin
            r_state <= ST_PUSH1;
            r_data  <= data_in;
          end else if (w_pop_ok) begin
            r_state <= ST_POP1;
          end
        end
        ST_PUSH1: r_state <= ST_PUSH2;
        ST_PUSH2: begin
          r_state <= ST_IDLE;
          r_count <= r_count + CNT_W'(1);
        end
        ST_POP1:  r_state <= ST_POP2;
        ST_POP2: begin
          r_state <= ST_IDLE;
          r_count <= r_count - CNT_W'(1);
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset mid-command drops them at once.
  assign push_o  = is_push_state(r_state);
  assign pop_o   = is_pop_state(r_state);
  assign data_o  = r_data;
  assign count_o = r_count;
  assign full_o  = w_full;
  assign empty_o = w_empty;

`ifdef STACK_CMD_ERR_EN
  logic w_reject;
  logic r_err;

  // Rejections: simultaneous requests, any request while busy, push when
  // full or pop when empty while idle.
  assign w_reject = (w_push_req && w_pop_req)
                  || ((r_state != ST_IDLE) && (w_push_req || w_pop_req))
                  || ((r_state == ST_IDLE) && w_push_req && !w_pop_req && w_full)
                  || ((r_state == ST_IDLE) && w_pop_req && !w_push_req && w_empty);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err <= 1'b0;
    end else if (w_reject) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// Directed bench for stack_cmd_frontend: button presses with hand-computed
// expected command pulses, captured data, occupancy and error flag.
module tb_stack_cmd_frontend;
  import stack_pkg::*;

`ifdef STACK_CMD_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        btn_push;
  logic        btn_pop;
  logic [7:0]  data_in;
  logic        push_o;
  logic        pop_o;
  logic [7:0]  data_o;
  logic [8:0]  count_o;
  logic        full_o;
  logic        empty_o;
  logic        err_o;

  int n_checks = 0;
  int n_err    = 0;

  // Monitor state, sampled on the falling edge.
  int         push_starts = 0;
  int         push_cycles = 0;
  int         pop_starts  = 0;
  int         pop_cycles  = 0;
  int         both_high   = 0;
  int         data_glitch = 0;
  logic [7:0] last_data   = 8'h00;
  logic       prev_push   = 1'b0;
  logic       prev_pop    = 1'b0;
  logic [7:0] prev_data   = 8'h00;

  int ps0, pc0, os0, oc0;

  stack_cmd_frontend dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_push (btn_push),
    .btn_pop  (btn_pop),
    .data_in  (data_in),
    .push_o   (push_o),
    .pop_o    (pop_o),
    .data_o   (data_o),
    .count_o  (count_o),
    .full_o   (full_o),
    .empty_o  (empty_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (push_o && !prev_push) push_starts++;
    if (pop_o && !prev_pop)   pop_starts++;
    if (push_o) begin
      push_cycles++;
      last_data = data_o;
      if (prev_push && (data_o != prev_data)) data_glitch++;
    end
    if (pop_o) pop_cycles++;
    if (push_o && pop_o) both_high++;
    prev_push = push_o;
    prev_pop  = pop_o;
    prev_data = data_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    ps0 = push_starts;
    pc0 = push_cycles;
    os0 = pop_starts;
    oc0 = pop_cycles;
  endtask

  // Press long enough for the debouncer to accept, release long enough for
  // it to settle low and for any command to finish.
  task automatic press(input logic p, input logic q, input logic [7:0] d);
    data_in  = d;
    btn_push = p;
    btn_pop  = q;
    wait_cyc(20);
    btn_push = 1'b0;
    btn_pop  = 1'b0;
    wait_cyc(22);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n    = 1'b0;
    btn_push = 1'b0;
    btn_pop  = 1'b0;
    data_in  = 8'h00;
    wait_cyc(3);

    // Reset state while reset is held.
    check("rst_push", push_o, 0);
    check("rst_pop", pop_o, 0);
    check("rst_data", data_o, 0);
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_err", err_o, 0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Held push with A5: one 2-cycle pulse, data captured, count 1.
    snap();
    press(1'b1, 1'b0, 8'hA5);
    check("p1_starts", push_starts - ps0, 1);
    check("p1_cycles", push_cycles - pc0, 2);
    check("p1_data", last_data, 8'hA5);
    check("p1_count", count_o, 1);
    check("p1_empty", empty_o, 0);
    check("p1_err", err_o, 0);

    // Bouncing push: toggles every 3 cycles never satisfy 16 stable samples.
    snap();
    for (int i = 0; i < 10; i++) begin
      btn_push = ~btn_push;
      wait_cyc(3);
    end
    btn_push = 1'b0;
    wait_cyc(22);
    check("bounce_starts", push_starts - ps0, 0);
    check("bounce_count", count_o, 1);

    // Pop back to empty.
    snap();
    press(1'b0, 1'b1, 8'h00);
    check("pop1_starts", pop_starts - os0, 1);
    check("pop1_cycles", pop_cycles - oc0, 2);
    check("pop1_count", count_o, 0);
    check("pop1_empty", empty_o, 1);

    // Pop from empty is rejected.
    snap();
    press(1'b0, 1'b1, 8'h00);
    check("pop_empty_starts", pop_starts - os0, 0);
    check("pop_empty_count", count_o, 0);
    check("pop_empty_err", err_o, ERR_EXP);

    // Reset during PUSH1 aborts the command and clears the error flag.
    data_in  = 8'h3C;
    btn_push = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (push_o) seen = 1'b1;
    end
    check("abort_seen_push", seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort_push_low", push_o, 0);
    check("abort_err", err_o, 0);
    btn_push = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(25);
    check("abort_count", count_o, 0);
    check("abort_empty", empty_o, 1);

    // FSM is back in idle: a fresh push is accepted.
    snap();
    press(1'b1, 1'b0, 8'h77);
    check("after_abort_starts", push_starts - ps0, 1);
    check("after_abort_data", last_data, 8'h77);
    check("after_abort_count", count_o, 1);

    // Both buttons in the same cycle: both rejected.
    snap();
    press(1'b1, 1'b1, 8'h11);
    check("both_push", push_starts - ps0, 0);
    check("both_pop", pop_starts - os0, 0);
    check("both_count", count_o, 1);
    check("both_err", err_o, ERR_EXP);

    // Pop arriving one cycle after push lands in PUSH1 and is dropped.
    do_reset();
    check("busy_pre_err", err_o, 0);
    snap();
    data_in  = 8'h5A;
    btn_push = 1'b1;
    wait_cyc(1);
    btn_pop  = 1'b1;
    wait_cyc(20);
    btn_push = 1'b0;
    btn_pop  = 1'b0;
    wait_cyc(22);
    check("busy_push", push_starts - ps0, 1);
    check("busy_pop", pop_starts - os0, 0);
    check("busy_count", count_o, 1);
    check("busy_err", err_o, ERR_EXP);

    // Fill to DEPTH, then one more push is rejected.
    do_reset();
    snap();
    for (int i = 0; i < 256; i++) begin
      press(1'b1, 1'b0, 8'(i));
    end
    check("fill_starts", push_starts - ps0, 256);
    check("fill_cycles", push_cycles - pc0, 512);
    check("fill_count", count_o, 256);
    check("fill_full", full_o, 1);
    check("fill_empty", empty_o, 0);
    check("fill_last_data", last_data, 8'hFF);
    check("fill_err", err_o, 0);
    snap();
    press(1'b1, 1'b0, 8'hEE);
    check("over_starts", push_starts - ps0, 0);
    check("over_count", count_o, 256);
    check("over_data", data_o, 8'hFF);
    check("over_err", err_o, ERR_EXP);
    press(1'b0, 1'b1, 8'h00);
    check("unfill_count", count_o, 255);
    check("unfill_full", full_o, 0);

    check("never_both", both_high, 0);
    check("data_stable", data_glitch, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
